// File: rtl/ds2x_frame_seq.sv
// ds2x_frame_seq: frame/line sequencer for the 2x2 averaging downscaler.
// It tracks the raster position of accepted pixels and drives the datapath
// phase, line-buffer address and strobes. It also owns the output handshake
// for the single outstanding downscaled result.
module ds2x_frame_seq #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int AW     = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          s_valid,
    input  logic          s_sof,
    output logic          s_ready,
    output logic          dp_en,
    output logic [1:0]    dp_phase,
    output logic [AW-1:0] dp_addr,
    output logic          dp_emit,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          busy,
    output logic          frame_done,
    output logic          err_sof
);

    localparam int XW = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;

    localparam logic [XW-1:0] XLAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YLAST = YW'(HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        ACTIVE,
        DRAIN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          m_valid_q, m_valid_d;

    // State, position counters and result-valid flag; reset wipes all progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            m_valid_q <= m_valid_d;
        end
    end

    // Next state, raster advance and datapath strobes for the accepted pixel.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        s_ready  = 1'b0;
        dp_en    = 1'b0;
        dp_phase = 2'b00;
        dp_addr  = '0;
        err_sof  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_SOF;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            WAIT_SOF: begin
                s_ready = 1'b1;
                if (s_valid && s_sof) begin
                    dp_en   = 1'b1;
                    x_d     = XW'(1);
                    y_d     = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                s_ready = ~(m_valid_q & ~m_ready);
                if (s_valid && s_ready) begin
                    dp_en = 1'b1;
                    if (s_sof) begin
                        err_sof = 1'b1;
                        x_d     = XW'(1);
                        y_d     = '0;
                    end else begin
                        dp_phase = {y_q[0], x_q[0]};
                        dp_addr  = AW'(x_q >> 1);
                        if (x_q == XLAST) begin
                            x_d = '0;
                            if (y_q == YLAST) begin
                                y_d     = '0;
                                state_d = DRAIN;
                            end else begin
                                y_d = y_q + YW'(1);
                            end
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (!m_valid_q || m_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A result is produced on every phase-11 accept; it stays until the sink takes it.
    always_comb begin
        dp_emit   = dp_en & (dp_phase == 2'b11);
        m_valid_d = m_valid_q;
        if (dp_emit) begin
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    assign m_valid    = m_valid_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_ds2x_frame_seq.sv
// tb_ds2x_frame_seq: randomized scoreboard bench for ds2x_frame_seq.
// A driver issues pixels and steps a frame-level reference model that counts
// pixels linearly; expected datapath strobes and results are queued and a
// separate monitor pops them whenever the DUT presents them.
module tb_ds2x_frame_seq;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int AW = 3;

    localparam int M_IDLE   = 0;
    localparam int M_WAIT   = 1;
    localparam int M_ACTIVE = 2;
    localparam int M_DRAIN  = 3;
    localparam int M_DONE   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          s_valid;
    logic          s_sof;
    logic          s_ready;
    logic          dp_en;
    logic [1:0]    dp_phase;
    logic [AW-1:0] dp_addr;
    logic          dp_emit;
    logic          m_valid;
    logic          m_ready;
    logic          busy;
    logic          frame_done;
    logic          err_sof;

    typedef struct {
        logic [1:0]    phase;
        logic [AW-1:0] addr;
        logic          emit;
        logic          err;
    } exp_t;

    exp_t expQ[$];
    int   resQ[$];

    int total = 0;
    int bad   = 0;

    int mode     = M_IDLE;
    int idx      = 0;
    bit pending  = 1'b0;
    int beats    = 0;
    int pValid   = 100;
    int pReady   = 100;
    int pSof     = 0;
    int dropCnt  = 0;
    int forceIdx = -1;
    bit doStart  = 1'b0;
    bit stray    = 1'b0;

    ds2x_frame_seq #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_valid    (s_valid),
        .s_sof      (s_sof),
        .s_ready    (s_ready),
        .dp_en      (dp_en),
        .dp_phase   (dp_phase),
        .dp_addr    (dp_addr),
        .dp_emit    (dp_emit),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .err_sof    (err_sof)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: one call per cycle, predicting what the next edge does.
    task automatic modelStep();
        bit   expReady;
        bit   acc;
        bit   emit;
        bit   xfer;
        int   x;
        int   y;
        exp_t e;
        expReady = (mode == M_WAIT) || (mode == M_ACTIVE && !(pending && !m_ready));
        checkOutput("s_ready", s_ready, expReady);
        checkOutput("m_valid", m_valid, pending);
        checkOutput("busy", busy, mode != M_IDLE);
        checkOutput("frame_done", frame_done, mode == M_DONE);
        acc  = s_valid && expReady;
        emit = 1'b0;
        xfer = pending && m_ready;
        case (mode)
            M_IDLE: if (start) mode = M_WAIT;
            M_WAIT: begin
                if (acc && s_sof) begin
                    e = '{phase: 2'b00, addr: '0, emit: 1'b0, err: 1'b0};
                    expQ.push_back(e);
                    idx  = 1;
                    mode = M_ACTIVE;
                end
            end
            M_ACTIVE: begin
                if (acc) begin
                    if (s_sof) begin
                        e   = '{phase: 2'b00, addr: '0, emit: 1'b0, err: 1'b1};
                        idx = 1;
                    end else begin
                        x       = idx % W;
                        y       = idx / W;
                        e.phase = {1'(y % 2), 1'(x % 2)};
                        e.addr  = AW'(x / 2);
                        e.emit  = (x % 2 == 1) && (y % 2 == 1);
                        e.err   = 1'b0;
                        emit    = e.emit;
                        idx++;
                        if (idx == W * H) mode = M_DRAIN;
                    end
                    expQ.push_back(e);
                    if (emit) resQ.push_back(idx);
                end
            end
            M_DRAIN: if (!pending || m_ready) mode = M_DONE;
            M_DONE: mode = M_IDLE;
            default: mode = M_IDLE;
        endcase
        pending = emit ? 1'b1 : (xfer ? 1'b0 : pending);
    endtask

    // Drives one cycle of random inputs just after the edge, then steps the model.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        start = doStart || (stray && mode != M_IDLE && $urandom_range(99) < 3);
        doStart = 1'b0;
        s_valid = ($urandom_range(99) < pValid);
        s_sof   = s_valid && ($urandom_range(999) < pSof);
        if (mode == M_WAIT) begin
            if (dropCnt > 0) begin
                s_valid = 1'b1;
                s_sof   = 1'b0;
                dropCnt--;
            end else begin
                s_sof = s_valid;
            end
        end
        if (mode == M_ACTIVE && idx == forceIdx) begin
            s_valid  = 1'b1;
            s_sof    = 1'b1;
            forceIdx = -1;
        end
        m_ready = ($urandom_range(99) < pReady);
        #1;
        modelStep();
    endtask

    task automatic applyReset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_outputs",
                    {s_ready, dp_en, dp_phase, dp_addr, dp_emit, m_valid, busy, frame_done, err_sof}, 0);
        mode    = M_IDLE;
        pending = 1'b0;
        idx     = 0;
        expQ.delete();
        resQ.delete();
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic runFrame(input int pv, input int pr, input int ps, input int drops,
                            input int fIdx, input int abortIdx, input bit clean, input bit strayStart);
        int n;
        pValid   = pv;
        pReady   = pr;
        pSof     = ps;
        dropCnt  = drops;
        forceIdx = fIdx;
        stray    = strayStart;
        beats    = 0;
        doStart  = 1'b1;
        n        = 0;
        do begin
            applyStimulus();
            n++;
            if (abortIdx >= 0 && mode == M_ACTIVE && idx >= abortIdx) applyReset();
        end while (mode != M_IDLE && n < 4000);
        if (n >= 4000) checkOutput("frame_timeout", mode, M_IDLE);
        stray = 1'b0;
        applyStimulus();
        checkOutput("results_delivered", resQ.size(), 0);
        if (clean) checkOutput("beats_per_frame", beats, (W / 2) * (H / 2));
    endtask

    // Monitor: pops expectations whenever the DUT strobes the datapath or hands off a result.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("dp_en", dp_en, expQ.size() != 0);
            if (expQ.size() != 0) begin
                exp_t e;
                e = expQ.pop_front();
                if (dp_en) begin
                    checkOutput("dp_phase", dp_phase, e.phase);
                    checkOutput("dp_addr", dp_addr, e.addr);
                    checkOutput("dp_emit", dp_emit, e.emit);
                    checkOutput("err_sof", err_sof, e.err);
                end
            end else if (err_sof || dp_emit) begin
                checkOutput("stray_strobe", {err_sof, dp_emit}, 0);
            end
            if (m_valid && m_ready) begin
                checkOutput("result_expected", resQ.size() != 0, 1);
                if (resQ.size() != 0) void'(resQ.pop_front());
                beats++;
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b1;
        s_sof   = 1'b0;
        m_ready = 1'b0;
        #2;
        checkOutput("reset_outputs",
                    {s_ready, dp_en, dp_phase, dp_addr, dp_emit, m_valid, busy, frame_done, err_sof}, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Idle with a valid source: nothing may be accepted.
        pValid = 100;
        repeat (3) applyStimulus();

        // Full-throughput frame preceded by five dropped non-sof pixels.
        runFrame(100, 100, 0, 5, -1, -1, 1'b1, 1'b0);
        // Random source gaps and sink backpressure, with stray starts.
        runFrame(70, 60, 0, 2, -1, -1, 1'b1, 1'b1);
        // Unexpected sof at pixel (10,3).
        runFrame(100, 100, 0, 0, 3 * W + 10, -1, 1'b0, 1'b0);
        // Occasional random sof restarts under backpressure.
        runFrame(80, 50, 5, 1, -1, -1, 1'b0, 1'b1);
        // Reset in the middle of the frame.
        runFrame(100, 70, 0, 0, -1, W * (H / 2) + 5, 1'b0, 1'b0);
        // Clean frame after the mid-frame reset.
        runFrame(100, 100, 0, 0, -1, -1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
